// File: rtl/cache_pkg.sv
// Shared encodings for the data cache: CPU load/store codes, request-field positions
// and the miss-handling state machine.
package cache_pkg;

    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int BLOCK_BITS        = 8 << BLOCK_OFFSET_BITS;

    // Bit positions of the enable flags inside READ_EN / WRITE_EN
    localparam int LOAD_EN_BIT  = 3;
    localparam int STORE_EN_BIT = 2;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        ST_SB = 2'b00,
        ST_SH = 2'b01,
        ST_SW = 2'b10
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        ALLOCATE
    } state_e;

endpackage

// File: rtl/data_cache_lane_align.sv
// Byte-lane steering between a 128-bit cache block and the 32-bit CPU port:
// load extraction with sign/zero extension, and store merge into the block.
module data_cache_lane_align
    import cache_pkg::*;
(
    input  logic [BLOCK_BITS-1:0] block,
    input  logic [1:0]            word_sel,
    input  logic [1:0]            byte_sel,
    input  logic [2:0]            load_op,
    input  logic [1:0]            store_size,
    input  logic [31:0]           store_data,
    output logic [31:0]           load_data,
    output logic [BLOCK_BITS-1:0] merged_block
);

    logic [6:0]  word_lsb;
    logic [6:0]  half_lsb;
    logic [6:0]  byte_lsb;
    logic [31:0] word;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    assign word_lsb = {word_sel, 5'b00000};
    assign half_lsb = {word_sel, byte_sel[1], 4'b0000};
    assign byte_lsb = {word_sel, byte_sel, 3'b000};

    assign word    = block[word_lsb +: 32];
    assign ld_half = word[{byte_sel[1], 4'b0000} +: 16];
    assign ld_byte = word[{byte_sel, 3'b000} +: 8];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        load_data = '0;
        case (load_op)
            LD_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            LD_LW:   load_data = word;
            LD_LBU:  load_data = {24'h0, ld_byte};
            LD_LHU:  load_data = {16'h0, ld_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged_block = block;
        case (store_size)
            ST_SB:   merged_block[byte_lsb +: 8]  = store_data[7:0];
            ST_SH:   merged_block[half_lsb +: 16] = store_data[15:0];
            ST_SW:   merged_block[word_lsb +: 32] = store_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache; stalls the pipeline via
// BUSY_WAIT while a dirty victim is written back and the missing block refilled.
module data_cache
    import cache_pkg::*;
#(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = BLOCK_OFFSET_BITS  // lane steering assumes 16-byte blocks
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [3:0]              READ_EN,
    input  logic [2:0]              WRITE_EN,
    input  logic [31:0]             ADDR,
    input  logic [31:0]             WRITE_DATA,
    output logic [31:0]             READ_DATA,
    output logic                    BUSY_WAIT,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [31-OFFSET_BITS:0] MEM_ADDR,
    output logic [BLOCK_BITS-1:0]   MEM_WRITEDATA,
    input  logic [BLOCK_BITS-1:0]   MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [BLOCK_BITS-1:0] data_mem [LINES];
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;
    state_e                state;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [INDEX_BITS-1:0] miss_index;
    logic                  load_req;
    logic                  store_req;
    logic                  request;
    logic                  hit;
    logic                  idle;
    logic                  write_hit;
    logic                  fill_done;
    logic [31:0]           load_data;
    logic [BLOCK_BITS-1:0] merged_block;

    assign req_tag   = ADDR[31 -: TAG_BITS];
    assign req_index = ADDR[OFFSET_BITS +: INDEX_BITS];
    assign load_req  = READ_EN[LOAD_EN_BIT];
    assign store_req = WRITE_EN[STORE_EN_BIT];
    assign request   = load_req | store_req;
    assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign idle      = (state == IDLE);
    assign write_hit = !RESET && idle && store_req && hit;
    assign fill_done = (state == FETCH) && !MEM_BUSYWAIT;

    // A simultaneous store takes priority, so the load result is suppressed.
    assign BUSY_WAIT = !RESET && request && !(hit && idle);
    assign READ_DATA = (!RESET && load_req && !store_req && hit && idle) ? load_data : '0;

    data_cache_lane_align u_lane_align (
        .block        (data_mem[req_index]),
        .word_sel     (ADDR[3:2]),
        .byte_sel     (ADDR[1:0]),
        .load_op      (READ_EN[2:0]),
        .store_size   (WRITE_EN[1:0]),
        .store_data   (WRITE_DATA),
        .load_data    (load_data),
        .merged_block (merged_block)
    );

    // NOTE: tag/data arrays are deliberately not reset; valid/dirty decide whether their contents matter.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data_mem[miss_index] <= MEM_READDATA;
        end else if (write_hit) begin
            data_mem[req_index] <= merged_block;
        end
        if (state == ALLOCATE) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end

    // Refill data is captured on the cycle memory completes (its bus is idle during
    // ALLOCATE); ALLOCATE then commits the tag and valid bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            miss_tag      <= '0;
            miss_index    <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_hit) begin
                        dirty[req_index] <= 1'b1;
                    end else if (request && !hit) begin
                        miss_tag   <= req_tag;
                        miss_index <= req_index;
                        if (valid[req_index] && dirty[req_index]) begin
                            state         <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDR      <= {tag_mem[req_index], req_index};
                            MEM_WRITEDATA <= data_mem[req_index];
                        end else begin
                            state    <= FETCH;
                            MEM_READ <= 1'b1;
                            MEM_ADDR <= {req_tag, req_index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state         <= FETCH;
                        MEM_WRITE     <= 1'b0;
                        MEM_READ      <= 1'b1;
                        MEM_ADDR      <= {miss_tag, miss_index};
                        MEM_WRITEDATA <= '0;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state    <= ALLOCATE;
                        MEM_READ <= 1'b0;
                        MEM_ADDR <= '0;
                    end
                end
                ALLOCATE: begin
                    valid[miss_index] <= 1'b1;
                    dirty[miss_index] <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus queues expected CPU responses and memory
// transfers; independent monitors compare them when the DUT presents them.
module tb_data_cache;

    localparam logic [3:0] NO_RD = 4'b0000;
    localparam logic [3:0] LB    = 4'b1000;
    localparam logic [3:0] LH    = 4'b1001;
    localparam logic [3:0] LW    = 4'b1010;
    localparam logic [3:0] LBU   = 4'b1100;
    localparam logic [3:0] LHU   = 4'b1101;
    localparam logic [2:0] NO_WR = 3'b000;
    localparam logic [2:0] SH    = 3'b101;
    localparam logic [2:0] SW    = 3'b110;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   READ_EN;
    logic [2:0]   WRITE_EN;
    logic [31:0]  ADDR;
    logic [31:0]  WRITE_DATA;
    logic [31:0]  READ_DATA;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ_EN       (READ_EN),
        .WRITE_EN      (WRITE_EN),
        .ADDR          (ADDR),
        .WRITE_DATA    (WRITE_DATA),
        .READ_DATA     (READ_DATA),
        .BUSY_WAIT     (BUSY_WAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Main memory: 64 blocks, each word initialised to 0x5A000000 | byte address.
    logic [127:0] mem [64];
    int           busy_cnt = 0;

    function automatic logic [127:0] init_block(input int b);
        logic [127:0] blk;
        for (int w = 0; w < 4; w++) blk[w*32 +: 32] = 32'h5A00_0000 | 32'(b * 16 + w * 4);
        return blk;
    endfunction

    initial begin
        for (int b = 0; b < 64; b++) mem[b] = init_block(b);
    end

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (busy_cnt < 5);
    assign MEM_READDATA = MEM_READ ? mem[MEM_ADDR[5:0]] : '0;

    always @(posedge CLK) begin
        if (!(MEM_READ || MEM_WRITE)) begin
            busy_cnt <= 0;
        end else if (MEM_BUSYWAIT) begin
            busy_cnt <= busy_cnt + 1;
        end else begin
            busy_cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDR[5:0]] <= MEM_WRITEDATA;
        end
    end

    // Scoreboard queues
    string        rsp_name_q [$];
    logic [31:0]  rsp_data_q [$];
    logic         mq_wr   [$];
    logic [27:0]  mq_addr [$];
    logic [127:0] mq_data [$];
    logic         exp_wr;
    logic         both_seen = 1'b0;

    // CPU-side monitor: a request completes on a cycle where BUSY_WAIT is low.
    always @(negedge CLK) begin
        if (!RESET && (READ_EN[3] || WRITE_EN[2]) && !BUSY_WAIT) begin
            if (rsp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got READ_DATA %h with no pending expectation", READ_DATA);
            end else begin
                check(rsp_name_q.pop_front(), 128'(READ_DATA), 128'(rsp_data_q.pop_front()));
            end
        end
    end

    // Memory-side monitor: a transfer completes on the first cycle MEM_BUSYWAIT is low.
    always @(negedge CLK) begin
        if (MEM_READ && MEM_WRITE) both_seen = 1'b1;
        if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            if (mq_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got rd=%b wr=%b addr %h", MEM_READ, MEM_WRITE, MEM_ADDR);
            end else begin
                exp_wr = mq_wr.pop_front();
                check("mem_dir", 128'({MEM_WRITE, MEM_READ}), exp_wr ? 128'(2'b10) : 128'(2'b01));
                check("mem_addr", 128'(MEM_ADDR), 128'(mq_addr.pop_front()));
                check("mem_wdata", MEM_WRITEDATA, mq_data.pop_front());
            end
        end
    end

    task automatic expect_fetch(input logic [27:0] blk_addr);
        mq_wr.push_back(1'b0);
        mq_addr.push_back(blk_addr);
        mq_data.push_back('0);
    endtask

    task automatic expect_wb(input logic [27:0] blk_addr, input logic [127:0] data);
        mq_wr.push_back(1'b1);
        mq_addr.push_back(blk_addr);
        mq_data.push_back(data);
    endtask

    // Called just after a posedge; holds the request until BUSY_WAIT falls.
    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int exp_lat, input string name);
        int lat;
        rsp_name_q.push_back(name);
        rsp_data_q.push_back(exp_data);
        READ_EN    = rd;
        WRITE_EN   = wr;
        ADDR       = addr;
        WRITE_DATA = wdata;
        lat = 0;
        @(negedge CLK);
        while (BUSY_WAIT && lat < 50) begin
            lat++;
            @(negedge CLK);
        end
        check({name, "_stall"}, 128'(lat), 128'(exp_lat));
        @(posedge CLK);
        #1;
        READ_EN  = NO_RD;
        WRITE_EN = NO_WR;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] blk;
        RESET      = 1'b1;
        READ_EN    = NO_RD;
        WRITE_EN   = NO_WR;
        ADDR       = '0;
        WRITE_DATA = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy_wait", 128'(BUSY_WAIT), 128'(0));
        check("rst_read_data", 128'(READ_DATA), 128'(0));
        check("rst_mem_read", 128'(MEM_READ), 128'(0));
        check("rst_mem_write", 128'(MEM_WRITE), 128'(0));
        check("rst_mem_addr", 128'(MEM_ADDR), 128'(0));
        check("rst_mem_wdata", MEM_WRITEDATA, 128'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Cold miss, then stores/loads hitting the same line with no stall
        expect_fetch(28'h4);
        access(LW, NO_WR, 32'h40, 32'h0, 32'h5A00_0040, 8, "lw_cold_miss");
        access(NO_RD, SW, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, "sw_hit");
        access(LB, NO_WR, 32'h41, 32'h0, 32'hFFFF_FFBE, 0, "lb_sign");
        access(LBU, NO_WR, 32'h41, 32'h0, 32'h0000_00BE, 0, "lbu_zero");
        access(LH, NO_WR, 32'h42, 32'h0, 32'hFFFF_DEAD, 0, "lh_sign");
        access(LHU, NO_WR, 32'h42, 32'h0, 32'h0000_DEAD, 0, "lhu_zero");
        access(LB, NO_WR, 32'h43, 32'h0, 32'hFFFF_FFDE, 0, "lb_byte3");
        access(LW, NO_WR, 32'h44, 32'h0, 32'h5A00_0044, 0, "lw_word1");

        // Dirty conflict at index 4: writeback of the merged block, then refill
        blk = init_block(4);
        blk[31:0] = 32'hDEAD_BEEF;
        expect_wb(28'h4, blk);
        expect_fetch(28'hC);
        access(LW, NO_WR, 32'hC0, 32'h0, 32'h5A00_00C0, 14, "lw_dirty_miss");

        // Load and store together on a hit: store wins, no load data
        access(LW, SW, 32'hC4, 32'h1122_3344, 32'h0, 0, "ld_st_both");
        access(LW, NO_WR, 32'hC4, 32'h0, 32'h1122_3344, 0, "lw_after_both");

        // Halfword store on a clean line touches only bytes 6-7
        expect_fetch(28'h5);
        access(LW, NO_WR, 32'h50, 32'h0, 32'h5A00_0050, 8, "lw_idx5_miss");
        access(NO_RD, SH, 32'h56, 32'hFFFF_1234, 32'h0, 0, "sh_hit");
        access(LW, NO_WR, 32'h54, 32'h0, 32'h1234_0054, 0, "lw_sh_word");
        access(LW, NO_WR, 32'h50, 32'h0, 32'h5A00_0050, 0, "lw_sh_word0");
        access(LW, NO_WR, 32'h58, 32'h0, 32'h5A00_0058, 0, "lw_sh_word2");
        blk = init_block(5);
        blk[63:32] = 32'h1234_0054;
        expect_wb(28'h5, blk);
        expect_fetch(28'hD);
        access(LW, NO_WR, 32'hD0, 32'h0, 32'h5A00_00D0, 14, "lw_evict_sh");

        // The combined load/store left index 4 dirty; the written-back block returns
        blk = init_block(12);
        blk[63:32] = 32'h1122_3344;
        expect_wb(28'hC, blk);
        expect_fetch(28'h4);
        access(LW, NO_WR, 32'h40, 32'h0, 32'hDEAD_BEEF, 14, "lw_refill_wb");

        // Reset during the second cycle of a fetch abandons it
        READ_EN = LW;
        ADDR    = 32'h80;
        @(negedge CLK);
        @(negedge CLK);
        check("fetch_started", 128'(MEM_READ), 128'(1));
        check("fetch_addr", 128'(MEM_ADDR), 128'(28'h8));
        @(posedge CLK);
        #1;
        RESET   = 1'b1;
        READ_EN = NO_RD;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort_mem_read", 128'(MEM_READ), 128'(0));
        check("abort_busy_wait", 128'(BUSY_WAIT), 128'(0));
        check("abort_mem_addr", 128'(MEM_ADDR), 128'(0));
        @(posedge CLK);
        #1;
        expect_fetch(28'h8);
        access(LW, NO_WR, 32'h80, 32'h0, 32'h5A00_0080, 8, "lw_after_abort");
        expect_fetch(28'h4);
        access(LW, NO_WR, 32'h40, 32'h0, 32'hDEAD_BEEF, 8, "lw_invalidated");

        repeat (3) @(negedge CLK);
        check("rsp_q_drain", 128'(rsp_data_q.size()), 128'(0));
        check("mem_q_drain", 128'(mq_wr.size()), 128'(0));
        check("never_rd_and_wr", 128'(both_seen), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
